// File: rtl/matrix_add_sequencer.sv
// Command sequencer around a combinational 5x5 int8 matrix adder.
// Define MATRIX_SEQ_ACC_EN to make EXEC also write the sum back into A.
module matrix_add_sequencer #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8,
    parameter int ROW_W  = DIM * ELEM_W,
    parameter int MAT_W  = DIM * ROW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROW_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_data,
    output logic [MAT_W-1:0] add_a,
    output logic [MAT_W-1:0] add_b,
    input  logic [MAT_W-1:0] add_result,
    input  logic             add_overflow,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_READ,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST = 3'(DIM - 1);

    state_t           state;
    logic [2:0]       cnt;
    logic             tgt_b;
    logic [MAT_W-1:0] a_q;
    logic [MAT_W-1:0] b_q;
    logic [MAT_W-1:0] c_q;

    assign add_a    = a_q;
    assign add_b    = b_q;
    assign out_data = c_q[32'(cnt)*ROW_W +: ROW_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tgt_b     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            ovf       <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cnt       <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        unique case (cmd_op)
                            2'b00, 2'b01: begin
                                tgt_b    <= cmd_op[0];
                                in_ready <= 1'b1;
                                state    <= S_LOAD;
                            end
                            2'b10: state <= S_EXEC;
                            default: begin
                                out_valid <= 1'b1;
                                state     <= S_READ;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        if (tgt_b)
                            b_q[32'(cnt)*ROW_W +: ROW_W] <= in_data;
                        else
                            a_q[32'(cnt)*ROW_W +: ROW_W] <= in_data;
                        if (cnt == LAST) begin
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                S_EXEC: begin
                    c_q <= add_result;
                    ovf <= add_overflow;
`ifdef MATRIX_SEQ_ACC_EN
                    a_q <= add_result;
`else
                    a_q <= a_q;
`endif
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_READ: begin
                    // cnt only moves on a handshake, so out_data holds under stall
                    if (out_valid && out_ready) begin
                        if (cnt == LAST) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/matrix_add_sequencer.md
# matrix_add_sequencer

Command-driven controller sequencing the combinational 5×5 signed int8 matrix adder. It buffers operands A and B, loaded row by row over a 40-bit stream, and drives them onto the adder's 200-bit operand buses. It captures the sum and overflow flag into a result register C and streams C back out row by row. It sits between the host-side command/stream interface and the adder instance.

## Interface
Parameters (fixed; not to be overridden):
- `DIM`, 5: matrix dimension (rows = columns).
- `ELEM_W`, 8: element width in bits, two's complement.
- `ROW_W`, 40: row width, `DIM*ELEM_W`.
- `MAT_W`, 200: matrix width, `DIM*ROW_W`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_op`  in  2  command: 00 LOAD_A, 01 LOAD_B, 10 EXEC, 11 READ_C.
- `in_valid`  in  1  input row valid.
- `in_ready`  out  1  high only in LOAD.
- `in_data`  in  40  input row; element j at `[j*8 +: 8]`.
- `out_valid`  out  1  output row valid, high only in READ.
- `out_ready`  in  1  consumer accepts row.
- `out_data`  out  40  current row of C.
- `add_a`  out  200  to adder `matrix_A`; continuously equals register A.
- `add_b`  out  200  to adder `matrix_B`; continuously equals register B.
- `add_result`  in  200  from adder `result_out`.
- `add_overflow`  in  1  from adder `overflow`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a command completes.
- `ovf`  out  1  overflow of the most recent EXEC.

## Operation
- Matrix layout: row r occupies `[r*40 +: 40]`. Element (r, j) is adder element index `r*5+j`.
- Rows are always transferred in order, row 0 first. A 3-bit row counter runs 0..4.
- Reset clears A, B, C, the row counter and `ovf` to 0. It forces state IDLE.
- Reset value of every output is 0, except `cmd_ready`, which is 1 because the block is in IDLE.
- FSM states: IDLE, LOAD, EXEC, READ, DONE.
- IDLE: on `cmd_valid`, the command is accepted. Transitions:
  - op 00/01 → LOAD, with target A or B latched.
  - op 10 → EXEC.
  - op 11 → READ.
  - The row counter is cleared on every accept.
- LOAD:
  - Each `in_valid & in_ready` cycle writes `in_data` into row[cnt] of the target register and increments cnt.
  - The handshake at cnt=4 → DONE.
  - Rows not yet written keep their previous contents.
- EXEC: lasts exactly one cycle.
  - At the end of the cycle: C ← `add_result`, `ovf` ← `add_overflow`.
  - Next state DONE.
- READ:
  - `out_data` = row[cnt] of C.
  - `out_data` is held stable while `out_valid & !out_ready`.
  - Each handshake increments cnt. The handshake at cnt=4 → DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Commands presented while busy are not accepted. They are held by the requester because `cmd_ready`=0.
- READ_C before any EXEC returns all-zero rows.
- EXEC may be issued repeatedly without reloading operands. `ovf` reflects only the latest EXEC.
- The block performs no arithmetic of its own. It relies on 8-bit wrap-around in the adder. `ovf` is the adder's OR-reduced signed-overflow flag.
- Reset asserted mid-LOAD or mid-READ aborts the transfer:
  - Registers are cleared.
  - No `done` pulse is produced.
  - The partially transferred rows are discarded.

## Timing
- Command accepted at edge T → new state active in cycle T+1.
- LOAD/READ:
  - `in_ready`/`out_valid` rise in cycle T+1.
  - Throughput is one row per cycle.
  - Minimum 5 cycles of transfer, then DONE in the next cycle.
  - Total minimum from accept to `cmd_ready` high: 7 cycles.
- EXEC:
  - EXEC state in cycle T+1; C/`ovf` update at the end of T+1.
  - `done` in T+2.
  - `cmd_ready` in T+3.
- `add_a`/`add_b` are register outputs, so the adder path is one full cycle, register to register.
- `busy` = !`cmd_ready`.
- `done` is never asserted in the same cycle as `cmd_ready`.

## Configuration
- `MATRIX_SEQ_ACC_EN` defined:
  - EXEC additionally writes `add_result` into A in the same cycle as C.
  - Successive EXECs therefore compute A ← A+B repeatedly (accumulation).
- Without the macro: A is modified only by LOAD_A.

## Test plan
- Reset then idle → `cmd_ready`=1, `busy`=0, `ovf`=0. READ_C returns 5 rows of 40'h0, followed by a single `done` pulse.
- LOAD_A all elements 8'h05, LOAD_B all 8'h03, EXEC, READ_C:
  - Every row reads 40'h0808080808.
  - `ovf`=0.
  - `done` asserted exactly 2 cycles after the EXEC accept.
- A element (0,0)=8'h7F, B element (0,0)=8'h01, all others 0, then EXEC:
  - Row 0 reads 40'h0000000080.
  - `ovf`=1.
- Follow-up: LOAD_B all zeros, then EXEC → `ovf`=0.
- READ_C with `out_ready` held low for 3 cycles on row 2 → `out_data` stays stable on row 2. No row is skipped or duplicated, and 5 handshakes total are observed.
- Assert `rst` after 2 rows of LOAD_A:
  - No `done` pulse.
  - Then LOAD_B 8'h01, EXEC, READ_C → all rows 40'h0101010101, because A was cleared.
- With `MATRIX_SEQ_ACC_EN`: A=8'h01, B=8'h02, three EXECs → C=8'h07 in every element. Without the macro, C=8'h03.
